linear_wgrad_acc: RTL and testbench

LINEAR_WGRAD_ACC -- requirements
Module: linear_wgrad_acc

---
 rtl/linear_wgrad_pkg.sv | 26 ++
 rtl/wgrad_mac.sv | 21 ++
 rtl/linear_wgrad_acc.sv | 243 ++++++++++++++++++++++++
 tb/tb_linear_wgrad_acc.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_wgrad_pkg.sv
// Shared constants for the linear-layer weight-gradient accumulator:
// FSM state encodings, tensor header offsets and the output header length.
package linear_wgrad_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_RD_LEN = 4'd1;
  localparam state_t S_CHK    = 4'd2;
  localparam state_t S_HDR    = 4'd3;
  localparam state_t S_LD_DY  = 4'd4;
  localparam state_t S_LD_X   = 4'd5;
`ifdef LINEAR_WGRAD_ACCUM_EN
  localparam state_t S_RD_W   = 4'd6;
`endif
  localparam state_t S_WR_W   = 4'd7;
  localparam state_t S_DONE   = 4'd8;
  localparam state_t S_ERR    = 4'd9;

  localparam int DIMS_OFS  = 0;
  localparam int LEN_OFS   = 1;
  localparam int DATA_OFS  = 2;
  localparam int W_HDR_LEN = 3;
  localparam int W_DIMS    = 2;

endpackage

// File: rtl/wgrad_mac.sv
// Combinational fixed-point multiply, arithmetic rescale and optional add:
// y = ((a * b) >>> FRAC_W) + acc, everything wrapping at DATA_W bits.
module wgrad_mac
  import linear_wgrad_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] y
);

  logic [2*DATA_W-1:0] prod;

  // Low 2*DATA_W bits of the sign-extended operands' product are the signed product.
  assign prod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign y    = DATA_W'($signed(prod) >>> FRAC_W) + acc;

endmodule

// File: rtl/linear_wgrad_acc.sv
// Weight gradient W[i*N+j] = (dy[i]*x[j]) >>> FRAC_W over handshaked word memories.
// Define LINEAR_WGRAD_ACCUM_EN to enable read-modify-write accumulation into W.
module linear_wgrad_acc
  import linear_wgrad_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int FRAC_W    = 0,
  parameter int MAX_ELEMS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              accum,
  output logic              done,
  output logic              err,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] dy_base,
  input  logic [ADDR_W-1:0] w_base,
  output logic              x_ren,
  output logic              dy_ren,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] dy_addr,
  input  logic [DATA_W-1:0] x_rdata,
  input  logic [DATA_W-1:0] dy_rdata,
  input  logic              x_ack,
  input  logic              dy_ack,
  output logic              w_ren,
  output logic              w_wen,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_wdata,
  input  logic [DATA_W-1:0] w_rdata,
  input  logic              w_ack,
  output logic              w_wt
);

  state_t              state;
  logic [DATA_W-1:0]   n_len, m_len, dy_reg, hdr_val, mac_x, mac_acc, mac_y;
  logic [ADDR_W-1:0]   total, elem, row_i, col_j;
  logic [1:0]          hdr_idx;
  logic                got_x, got_dy, last_elem;
  logic [2*DATA_W-1:0] n_times_m;

`ifdef LINEAR_WGRAD_ACCUM_EN
  logic              acc_mode;
  logic [DATA_W-1:0] x_reg;
  assign mac_x   = (state == S_LD_X) ? x_rdata : x_reg;
  assign mac_acc = acc_mode ? w_rdata : '0;
`else
  logic unused_ins;
  assign unused_ins = ^{accum, w_rdata};
  assign mac_x      = x_rdata;
  assign mac_acc    = '0;
`endif

  assign n_times_m = {{DATA_W{1'b0}}, n_len} * {{DATA_W{1'b0}}, m_len};
  assign last_elem = (elem == total - ADDR_W'(1));

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    hdr_val = DATA_W'(W_DIMS);
    if (hdr_idx == 2'd1)      hdr_val = n_len;
    else if (hdr_idx == 2'd2) hdr_val = m_len;
  end

  wgrad_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mac (
    .a   (dy_reg),
    .b   (mac_x),
    .acc (mac_acc),
    .y   (mac_y)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      x_ren   <= 1'b0;
      dy_ren  <= 1'b0;
      w_ren   <= 1'b0;
      w_wen   <= 1'b0;
      w_wt    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      x_addr  <= '0;
      dy_addr <= '0;
      w_addr  <= '0;
      w_wdata <= '0;
      n_len   <= '0;
      m_len   <= '0;
      dy_reg  <= '0;
      total   <= '0;
      elem    <= '0;
      row_i   <= '0;
      col_j   <= '0;
      hdr_idx <= '0;
      got_x   <= 1'b0;
      got_dy  <= 1'b0;
`ifdef LINEAR_WGRAD_ACCUM_EN
      acc_mode <= 1'b0;
      x_reg    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (go) begin
          state   <= S_RD_LEN;
          x_ren   <= 1'b1;
          dy_ren  <= 1'b1;
          x_addr  <= x_base + ADDR_W'(LEN_OFS);
          dy_addr <= dy_base + ADDR_W'(LEN_OFS);
          got_x   <= 1'b0;
          got_dy  <= 1'b0;
          elem    <= '0;
          row_i   <= '0;
          col_j   <= '0;
          hdr_idx <= '0;
`ifdef LINEAR_WGRAD_ACCUM_EN
          acc_mode <= accum;
`endif
        end
        S_RD_LEN: begin
          if (x_ren && x_ack) begin
            x_ren <= 1'b0;
            n_len <= x_rdata;
            got_x <= 1'b1;
          end
          if (dy_ren && dy_ack) begin
            dy_ren <= 1'b0;
            m_len  <= dy_rdata;
            got_dy <= 1'b1;
          end
          if ((got_x || (x_ren && x_ack)) && (got_dy || (dy_ren && dy_ack)))
            state <= S_CHK;
        end
        S_CHK: begin
          if (n_times_m > (2*DATA_W)'(MAX_ELEMS)) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else begin
            total <= ADDR_W'(n_times_m);
            state <= S_HDR;
          end
        end
        S_HDR: begin
          if (!w_wen && !w_ren) begin
            w_addr <= w_base + ADDR_W'(hdr_idx);
`ifdef LINEAR_WGRAD_ACCUM_EN
            if (acc_mode) w_ren <= 1'b1; else
`endif
            begin
              w_wen   <= 1'b1;
              w_wdata <= hdr_val;
              w_wt    <= (hdr_idx == 2'd2) && (total == '0);
            end
          end else if (w_ack) begin
            w_wen <= 1'b0;
            w_ren <= 1'b0;
            w_wt  <= 1'b0;
`ifdef LINEAR_WGRAD_ACCUM_EN
            if (acc_mode && (w_rdata != hdr_val)) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else
`endif
            if (hdr_idx != 2'd2) begin
              hdr_idx <= hdr_idx + 2'd1;
            end else if (total == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_LD_DY;
              dy_ren  <= 1'b1;
              dy_addr <= dy_base + ADDR_W'(DATA_OFS);
            end
          end
        end
        S_LD_DY: if (dy_ren && dy_ack) begin
          dy_ren <= 1'b0;
          dy_reg <= dy_rdata;
          x_ren  <= 1'b1;
          x_addr <= x_base + ADDR_W'(DATA_OFS) + col_j;
          state  <= S_LD_X;
        end
        S_LD_X: if (x_ren && x_ack) begin
          x_ren  <= 1'b0;
          w_addr <= w_base + ADDR_W'(W_HDR_LEN) + elem;
`ifdef LINEAR_WGRAD_ACCUM_EN
          x_reg  <= x_rdata;
          if (acc_mode) state <= S_RD_W; else
`endif
          begin
            w_wdata <= mac_y;
            state   <= S_WR_W;
          end
        end
`ifdef LINEAR_WGRAD_ACCUM_EN
        S_RD_W: begin
          if (!w_ren) begin
            w_ren <= 1'b1;
          end else if (w_ack) begin
            w_ren   <= 1'b0;
            w_wdata <= mac_y;
            state   <= S_WR_W;
          end
        end
`endif
        S_WR_W: begin
          if (!w_wen) begin
            w_wen <= 1'b1;
            w_wt  <= last_elem;
          end else if (w_ack) begin
            w_wen <= 1'b0;
            w_wt  <= 1'b0;
            if (last_elem) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              elem <= elem + ADDR_W'(1);
              if (col_j + ADDR_W'(1) == ADDR_W'(n_len)) begin
                col_j   <= '0;
                row_i   <= row_i + ADDR_W'(1);
                dy_ren  <= 1'b1;
                dy_addr <= dy_base + ADDR_W'(DATA_OFS) + row_i + ADDR_W'(1);
                state   <= S_LD_DY;
              end else begin
                col_j  <= col_j + ADDR_W'(1);
                x_ren  <= 1'b1;
                x_addr <= x_base + ADDR_W'(DATA_OFS) + col_j + ADDR_W'(1);
                state  <= S_LD_X;
              end
            end
          end
        end
        S_DONE, S_ERR: if (!go) begin
          state <= S_IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_wgrad_acc.sv
// Directed bench for linear_wgrad_acc: two instances (FRAC_W=0/MAX 4096 and
// FRAC_W=8/MAX 4) share one handshaked memory model, selected by sel.
`timescale 1ns/1ps
module tb_linear_wgrad_acc;
  import linear_wgrad_pkg::*;

  localparam logic [31:0] XB = 32'h10, DB = 32'h40, WB = 32'h80;

  logic clk = 1'b0, rst = 1'b1, go = 1'b0, accum = 1'b0, sel = 1'b0;
  logic [31:0] x_base = XB, dy_base = DB, w_base = WB;
  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  logic        d0_done, d0_err, d0_x_ren, d0_dy_ren, d0_w_ren, d0_w_wen, d0_w_wt;
  logic [31:0] d0_x_addr, d0_dy_addr, d0_w_addr, d0_w_wdata;
  logic        d1_done, d1_err, d1_x_ren, d1_dy_ren, d1_w_ren, d1_w_wen, d1_w_wt;
  logic [31:0] d1_x_addr, d1_dy_addr, d1_w_addr, d1_w_wdata;
  logic        d0_go, d1_go, d0_x_ack, d0_dy_ack, d0_w_ack, d1_x_ack, d1_dy_ack, d1_w_ack;
  logic [31:0] x_rdata = '0, dy_rdata = '0, w_rdata = '0;
  logic        x_ack_m = 1'b0, dy_ack_m = 1'b0, w_ack_m = 1'b0, x_ack_force = 1'b0, x_stall = 1'b0;

  logic        m_x_ren, m_dy_ren, m_w_ren, m_w_wen, m_w_wt, cur_done, cur_err;
  logic [31:0] m_x_addr, m_dy_addr, m_w_addr, m_w_wdata;

  assign d0_go     = go & ~sel;
  assign d1_go     = go & sel;
  assign d0_x_ack  = ~sel & (x_ack_m | x_ack_force);
  assign d1_x_ack  = sel & (x_ack_m | x_ack_force);
  assign d0_dy_ack = ~sel & dy_ack_m;
  assign d1_dy_ack = sel & dy_ack_m;
  assign d0_w_ack  = ~sel & w_ack_m;
  assign d1_w_ack  = sel & w_ack_m;
  assign m_x_ren   = sel ? d1_x_ren : d0_x_ren;
  assign m_dy_ren  = sel ? d1_dy_ren : d0_dy_ren;
  assign m_w_ren   = sel ? d1_w_ren : d0_w_ren;
  assign m_w_wen   = sel ? d1_w_wen : d0_w_wen;
  assign m_w_wt    = sel ? d1_w_wt : d0_w_wt;
  assign m_x_addr  = sel ? d1_x_addr : d0_x_addr;
  assign m_dy_addr = sel ? d1_dy_addr : d0_dy_addr;
  assign m_w_addr  = sel ? d1_w_addr : d0_w_addr;
  assign m_w_wdata = sel ? d1_w_wdata : d0_w_wdata;
  assign cur_done  = sel ? d1_done : d0_done;
  assign cur_err   = sel ? d1_err : d0_err;

  linear_wgrad_acc #(.DATA_W(32), .ADDR_W(32), .FRAC_W(0), .MAX_ELEMS(4096)) dut0 (
    .clk(clk), .rst(rst), .go(d0_go), .accum(accum), .done(d0_done), .err(d0_err),
    .x_base(x_base), .dy_base(dy_base), .w_base(w_base),
    .x_ren(d0_x_ren), .dy_ren(d0_dy_ren), .x_addr(d0_x_addr), .dy_addr(d0_dy_addr),
    .x_rdata(x_rdata), .dy_rdata(dy_rdata), .x_ack(d0_x_ack), .dy_ack(d0_dy_ack),
    .w_ren(d0_w_ren), .w_wen(d0_w_wen), .w_addr(d0_w_addr), .w_wdata(d0_w_wdata),
    .w_rdata(w_rdata), .w_ack(d0_w_ack), .w_wt(d0_w_wt));

  linear_wgrad_acc #(.DATA_W(32), .ADDR_W(32), .FRAC_W(8), .MAX_ELEMS(4)) dut1 (
    .clk(clk), .rst(rst), .go(d1_go), .accum(accum), .done(d1_done), .err(d1_err),
    .x_base(x_base), .dy_base(dy_base), .w_base(w_base),
    .x_ren(d1_x_ren), .dy_ren(d1_dy_ren), .x_addr(d1_x_addr), .dy_addr(d1_dy_addr),
    .x_rdata(x_rdata), .dy_rdata(dy_rdata), .x_ack(d1_x_ack), .dy_ack(d1_dy_ack),
    .w_ren(d1_w_ren), .w_wen(d1_w_wen), .w_addr(d1_w_addr), .w_wdata(d1_w_wdata),
    .w_rdata(w_rdata), .w_ack(d1_w_ack), .w_wt(d1_w_wt));

  // Memory model: one-cycle ack per request, statistics on W traffic.
  logic [31:0] mem [0:511];
  int x_rd_cnt, dy_rd_cnt, w_rd_cnt, w_wr_cnt, wt_cnt;
  logic [31:0] wt_addr;

  always @(posedge clk) begin
    x_ack_m  <= 1'b0;
    dy_ack_m <= 1'b0;
    w_ack_m  <= 1'b0;
    if (m_x_ren && !x_ack_m && !x_stall) begin
      x_ack_m  <= 1'b1;
      x_rdata  <= mem[m_x_addr[8:0]];
      x_rd_cnt = x_rd_cnt + 1;
    end
    if (m_dy_ren && !dy_ack_m) begin
      dy_ack_m  <= 1'b1;
      dy_rdata  <= mem[m_dy_addr[8:0]];
      dy_rd_cnt = dy_rd_cnt + 1;
    end
    if (m_w_ren && !w_ack_m) begin
      w_ack_m  <= 1'b1;
      w_rdata  <= mem[m_w_addr[8:0]];
      w_rd_cnt = w_rd_cnt + 1;
    end else if (m_w_wen && !w_ack_m) begin
      w_ack_m  <= 1'b1;
      mem[m_w_addr[8:0]] = m_w_wdata;
      w_wr_cnt = w_wr_cnt + 1;
      if (m_w_wt) begin
        wt_cnt  = wt_cnt + 1;
        wt_addr = m_w_addr;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = '0;
    x_rd_cnt = 0; dy_rd_cnt = 0; w_rd_cnt = 0; w_wr_cnt = 0; wt_cnt = 0; wt_addr = '0;
  endtask

  task automatic run_op(input logic s, input logic acc, input logic pulse, output logic fin);
    sel = s;
    accum = acc;
    fin = 1'b0;
    @(negedge clk);
    go = 1'b1;
    if (pulse) begin
      @(negedge clk);
      go = 1'b0;
    end
    for (int c = 0; c < 2000; c++) begin
      if (cur_done || cur_err) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_go();
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({d0_x_ren, d0_dy_ren, d0_w_ren, d0_w_wen, d0_w_wt, d0_done, d0_err} !== 7'b0)
      $display("FAIL reset_ctl0: got %b want 0", {d0_x_ren, d0_dy_ren, d0_w_ren, d0_w_wen, d0_w_wt, d0_done, d0_err});
    else n_pass++;
    n_checks++;
    if ({d0_x_addr, d0_dy_addr, d0_w_addr, d0_w_wdata} !== 128'b0)
      $display("FAIL reset_addr0: got %h want 0", {d0_x_addr, d0_dy_addr, d0_w_addr, d0_w_wdata});
    else n_pass++;
    n_checks++;
    if ({d1_x_ren, d1_dy_ren, d1_w_ren, d1_w_wen, d1_w_wt, d1_done, d1_err} !== 7'b0)
      $display("FAIL reset_ctl1: got %b want 0", {d1_x_ren, d1_dy_ren, d1_w_ren, d1_w_wen, d1_w_wt, d1_done, d1_err});
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({d0_x_ren, d0_dy_ren, d0_done, d0_err} !== 4'b0)
      $display("FAIL reset_idle: got %b want 0", {d0_x_ren, d0_dy_ren, d0_done, d0_err});
    else n_pass++;
  endtask

  task automatic test_basic();
    logic fin;
    logic [31:0] exp_w [0:8];
    exp_w = '{32'd2, 32'd3, 32'd2, 32'd4, 32'd8, 32'd12, 32'd5, 32'd10, 32'd15};
    clear_mem();
    mem[XB] = 1; mem[XB+1] = 3; mem[XB+2] = 1; mem[XB+3] = 2; mem[XB+4] = 3;
    mem[DB] = 1; mem[DB+1] = 2; mem[DB+2] = 4; mem[DB+3] = 5;
    run_op(1'b0, 1'b0, 1'b0, fin);
    n_checks++;
    if (fin !== 1'b1 || d0_done !== 1'b1) $display("FAIL basic_done: got fin=%b done=%b want 1/1", fin, d0_done);
    else n_pass++;
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (mem[WB+k] !== exp_w[k]) $display("FAIL basic_w%0d: got %0d want %0d", k, mem[WB+k], exp_w[k]);
      else n_pass++;
    end
    n_checks++;
    if (wt_cnt !== 1 || wt_addr !== WB + 8) $display("FAIL basic_wt: got cnt=%0d addr=%h want 1/%h", wt_cnt, wt_addr, WB + 8);
    else n_pass++;
    n_checks++;
    if (w_wr_cnt !== 9) $display("FAIL basic_wr_cnt: got %0d want 9", w_wr_cnt);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (d0_done !== 1'b1) $display("FAIL basic_done_hold: got %b want 1", d0_done);
    else n_pass++;
    release_go();
    n_checks++;
    if (d0_done !== 1'b0 || dut0.state !== S_IDLE) $display("FAIL basic_release: got done=%b state=%0d want 0/%0d", d0_done, dut0.state, S_IDLE);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic fin;
    clear_mem();
    mem[XB] = 1; mem[XB+1] = 1; mem[XB+2] = 7;
    mem[DB] = 1; mem[DB+1] = 1; mem[DB+2] = 32'hFFFF_FFFE;
    run_op(1'b0, 1'b0, 1'b1, fin);
    n_checks++;
    if (fin !== 1'b1) $display("FAIL b2b_pulse_done: got %b want 1", fin);
    else n_pass++;
    n_checks++;
    if (mem[WB+3] !== 32'hFFFF_FFF2) $display("FAIL b2b_w: got %h want fffffff2", mem[WB+3]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (d0_done !== 1'b0) $display("FAIL b2b_auto_idle: got %b want 0", d0_done);
    else n_pass++;
  endtask

  task automatic test_frac();
    logic fin;
    clear_mem();
    mem[XB] = 1; mem[XB+1] = 1; mem[XB+2] = 32'h0000_0180;
    mem[DB] = 1; mem[DB+1] = 1; mem[DB+2] = 32'hFFFF_FF00;
    run_op(1'b1, 1'b0, 1'b0, fin);
    n_checks++;
    if (fin !== 1'b1 || d1_done !== 1'b1) $display("FAIL frac_done: got fin=%b done=%b want 1/1", fin, d1_done);
    else n_pass++;
    n_checks++;
    if (mem[WB+3] !== 32'hFFFF_FE80) $display("FAIL frac_w: got %h want fffffe80", mem[WB+3]);
    else n_pass++;
    n_checks++;
    if (wt_addr !== WB + 3) $display("FAIL frac_wt: got %h want %h", wt_addr, WB + 3);
    else n_pass++;
    release_go();
  endtask

  task automatic test_max_elems();
    logic fin;
    clear_mem();
    mem[XB] = 1; mem[XB+1] = 3; mem[DB] = 1; mem[DB+1] = 2;
    run_op(1'b1, 1'b0, 1'b0, fin);
    n_checks++;
    if (fin !== 1'b1 || d1_err !== 1'b1 || d1_done !== 1'b0) $display("FAIL max_err: got err=%b done=%b want 1/0", d1_err, d1_done);
    else n_pass++;
    n_checks++;
    if (w_rd_cnt + w_wr_cnt !== 0) $display("FAIL max_no_w: got %0d W accesses want 0", w_rd_cnt + w_wr_cnt);
    else n_pass++;
    release_go();
    n_checks++;
    if (d1_err !== 1'b0 || dut1.state !== S_IDLE) $display("FAIL max_release: got err=%b state=%0d want 0/%0d", d1_err, dut1.state, S_IDLE);
    else n_pass++;
  endtask

  task automatic test_empty();
    logic fin;
    clear_mem();
    mem[XB] = 1; mem[XB+1] = 0; mem[DB] = 1; mem[DB+1] = 5;
    mem[WB+3] = 32'hDEAD;
    run_op(1'b0, 1'b0, 1'b0, fin);
    n_checks++;
    if (fin !== 1'b1 || d0_done !== 1'b1) $display("FAIL empty_done: got fin=%b done=%b want 1/1", fin, d0_done);
    else n_pass++;
    n_checks++;
    if ({mem[WB], mem[WB+1], mem[WB+2]} !== {32'd2, 32'd0, 32'd5})
      $display("FAIL empty_hdr: got %0d %0d %0d want 2 0 5", mem[WB], mem[WB+1], mem[WB+2]);
    else n_pass++;
    n_checks++;
    if (wt_cnt !== 1 || wt_addr !== WB + 2) $display("FAIL empty_wt: got cnt=%0d addr=%h want 1/%h", wt_cnt, wt_addr, WB + 2);
    else n_pass++;
    n_checks++;
    if (w_wr_cnt !== 3 || x_rd_cnt !== 1 || dy_rd_cnt !== 1 || mem[WB+3] !== 32'hDEAD)
      $display("FAIL empty_no_data: got wr=%0d xr=%0d dyr=%0d w3=%h want 3 1 1 dead", w_wr_cnt, x_rd_cnt, dy_rd_cnt, mem[WB+3]);
    else n_pass++;
    release_go();
  endtask

  task automatic test_accum();
    logic fin;
    clear_mem();
    mem[XB] = 1; mem[XB+1] = 2; mem[XB+2] = 1; mem[XB+3] = 2;
    mem[DB] = 1; mem[DB+1] = 1; mem[DB+2] = 3;
    mem[WB] = 2; mem[WB+1] = 2; mem[WB+2] = 1; mem[WB+3] = 10; mem[WB+4] = 20;
    run_op(1'b0, 1'b1, 1'b0, fin);
`ifdef LINEAR_WGRAD_ACCUM_EN
    n_checks++;
    if (fin !== 1'b1 || d0_done !== 1'b1) $display("FAIL accum_done: got fin=%b done=%b want 1/1", fin, d0_done);
    else n_pass++;
    n_checks++;
    if (mem[WB+3] !== 32'd13 || mem[WB+4] !== 32'd26) $display("FAIL accum_w: got %0d %0d want 13 26", mem[WB+3], mem[WB+4]);
    else n_pass++;
    n_checks++;
    if (w_rd_cnt !== 5 || w_wr_cnt !== 2) $display("FAIL accum_traffic: got rd=%0d wr=%0d want 5 2", w_rd_cnt, w_wr_cnt);
    else n_pass++;
    release_go();
    clear_mem();
    mem[XB] = 1; mem[XB+1] = 2; mem[XB+2] = 1; mem[XB+3] = 2;
    mem[DB] = 1; mem[DB+1] = 1; mem[DB+2] = 3;
    mem[WB] = 2; mem[WB+1] = 2; mem[WB+2] = 2; mem[WB+3] = 10; mem[WB+4] = 20;
    run_op(1'b0, 1'b1, 1'b0, fin);
    n_checks++;
    if (fin !== 1'b1 || d0_err !== 1'b1) $display("FAIL accum_hdr_err: got fin=%b err=%b want 1/1", fin, d0_err);
    else n_pass++;
    n_checks++;
    if (w_wr_cnt !== 0 || mem[WB+3] !== 32'd10) $display("FAIL accum_hdr_nowr: got wr=%0d w3=%0d want 0 10", w_wr_cnt, mem[WB+3]);
    else n_pass++;
`else
    n_checks++;
    if (fin !== 1'b1 || d0_done !== 1'b1) $display("FAIL accum_off_done: got fin=%b done=%b want 1/1", fin, d0_done);
    else n_pass++;
    n_checks++;
    if (mem[WB+3] !== 32'd3 || mem[WB+4] !== 32'd6 || mem[WB+2] !== 32'd1)
      $display("FAIL accum_off_w: got %0d %0d %0d want 1 3 6", mem[WB+2], mem[WB+3], mem[WB+4]);
    else n_pass++;
    n_checks++;
    if (w_rd_cnt !== 0) $display("FAIL accum_off_no_rd: got %0d want 0", w_rd_cnt);
    else n_pass++;
`endif
    accum = 1'b0;
    release_go();
  endtask

  task automatic test_reset_pending();
    logic seen;
    clear_mem();
    mem[XB] = 1; mem[XB+1] = 2; mem[DB] = 1; mem[DB+1] = 2;
    sel = 1'b0;
    x_stall = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    go = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d0_x_ren) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (seen !== 1'b1) $display("FAIL rstp_pending: got x_ren=%b want 1", d0_x_ren);
    else n_pass++;
    rst = 1'b1;
    go = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({d0_x_ren, d0_dy_ren, d0_w_ren, d0_w_wen, d0_w_wt, d0_done, d0_err} !== 7'b0 ||
        {d0_x_addr, d0_dy_addr, d0_w_addr, d0_w_wdata} !== 128'b0)
      $display("FAIL rstp_outputs: got ctl=%b addr=%h want 0", {d0_x_ren, d0_dy_ren, d0_w_ren, d0_w_wen, d0_w_wt, d0_done, d0_err}, d0_x_addr);
    else n_pass++;
    n_checks++;
    if (dut0.state !== S_IDLE) $display("FAIL rstp_state: got %0d want %0d", dut0.state, S_IDLE);
    else n_pass++;
    rst = 1'b0;
    x_ack_force = 1'b1;
    x_rdata = 32'd9;
    @(negedge clk);
    x_ack_force = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut0.state !== S_IDLE || {d0_x_ren, d0_dy_ren, d0_done, d0_err} !== 4'b0)
      $display("FAIL rstp_late_ack: got state=%0d ctl=%b want %0d/0", dut0.state, {d0_x_ren, d0_dy_ren, d0_done, d0_err}, S_IDLE);
    else n_pass++;
    x_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frac();
    test_max_elems();
    test_empty();
    test_accum();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
